// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle for the immediate encoder.
// Master drives requests and consumes results; slave is the encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, in_sel, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_sel, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Scatters an immediate into an instruction's format fields, range-checks it,
// and queues {inst, err} in a small FIFO behind valid/ready handshakes.
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   enc_inst;
    logic          enc_err;
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    always_comb begin
        enc_inst = bus.in_base;
        enc_err  = 1'b0;
        unique case (bus.in_sel)
            3'b001: begin
                enc_inst[31:20] = bus.in_imm[11:0];
                enc_err = ~(&bus.in_imm[31:11] | ~|bus.in_imm[31:11]);
            end
            3'b010: begin
                enc_inst[31:25] = bus.in_imm[11:5];
                enc_inst[11:7]  = bus.in_imm[4:0];
                enc_err = ~(&bus.in_imm[31:11] | ~|bus.in_imm[31:11]);
            end
            3'b011: begin
                enc_inst[31]    = bus.in_imm[12];
                enc_inst[30:25] = bus.in_imm[10:5];
                enc_inst[11:8]  = bus.in_imm[4:1];
                enc_inst[7]     = bus.in_imm[11];
                enc_err = ~(&bus.in_imm[31:12] | ~|bus.in_imm[31:12])
                        | bus.in_imm[0];
            end
            3'b100: begin
                enc_inst[31]    = bus.in_imm[20];
                enc_inst[30:21] = bus.in_imm[10:1];
                enc_inst[20]    = bus.in_imm[11];
                enc_inst[19:12] = bus.in_imm[19:12];
                enc_err = ~(&bus.in_imm[31:20] | ~|bus.in_imm[31:20])
                        | bus.in_imm[0];
            end
            3'b000: begin
                enc_inst[31:12] = bus.in_imm[31:12];
                enc_err = |bus.in_imm[11:0];
            end
            default: enc_err = 1'b1;
        endcase
    end

    // Ready comes from registered occupancy only, so a full FIFO never
    // accepts even when the head is being popped in the same cycle.
    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign bus.out_inst = bus.out_valid ? mem[rd_ptr][32:1] : 32'd0;
    assign bus.out_err  = bus.out_valid ? mem[rd_ptr][0] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enc_inst, enc_err};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && enc_count != '1) begin
                enc_count <= enc_count + CNT_W'(1);
            end
            if (push && enc_err && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end
endmodule
